// File: rtl/mdu_pkg.sv
// Shared types and sizing helpers for the iterative multiply/accumulate unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_MADD  = 2'b10,
        MD_MADDU = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } mdu_state_t;

    localparam int unsigned MDU_WORD = 32;

    // RUN length for a given number of multiplier bits retired per cycle
    function automatic int unsigned mdu_run_len(int unsigned bpc);
        return MDU_WORD / bpc;
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One shift-add step: adds multiplicand x slice, placed at bit position shift.
module mdu_step #(
    parameter int unsigned BPC = 1
) (
    input  logic [31:0]    multiplicand,
    input  logic [63:0]    prod,
    input  logic [BPC-1:0] slice,
    input  logic [5:0]     shift,
    output logic [63:0]    prod_next
);

    logic [63:0] term;

    always_comb begin
        term      = {32'b0, multiplicand} * {{(64-BPC){1'b0}}, slice};
        prod_next = prod + (term << shift);
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative MULT/MULTU/MADD/MADDU sequencer owning HI/LO.
// Define MDU_EARLY_OUT_EN to leave RUN once the remaining multiplier is zero.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int unsigned BPC = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        rd_req,
    input  logic        rd_sel,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic [31:0] rd_data,
    output logic        done
);

    localparam int unsigned N = mdu_run_len(BPC);

    mdu_state_t  state_q;
    md_op_t      op_q;
    logic [31:0] mcand_q;
    logic [31:0] mplier_q;
    logic        neg_q;
    logic [63:0] prod_q;
    logic [63:0] snap_q;
    logic [5:0]  cnt_q;
    logic [5:0]  sh_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;

    md_op_t      op_in;
    logic        signed_op;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [31:0] mplier_next;
    logic [63:0] prod_step;
    logic [63:0] signed_prod;
    logic [63:0] fix_result;
    logic        run_end;

    mdu_step #(.BPC(BPC)) u_step (
        .multiplicand (mcand_q),
        .prod         (prod_q),
        .slice        (mplier_q[BPC-1:0]),
        .shift        (sh_q),
        .prod_next    (prod_step)
    );

    // 0x80000000 negates to itself, which read unsigned is exactly 2^31
    always_comb begin
        op_in       = md_op_t'(op);
        signed_op   = (op_in == MD_MULT) || (op_in == MD_MADD);
        a_abs       = (signed_op && src_a[31]) ? (~src_a + 32'd1) : src_a;
        b_abs       = (signed_op && src_b[31]) ? (~src_b + 32'd1) : src_b;
        mplier_next = mplier_q >> BPC;
        signed_prod = neg_q ? (~prod_q + 64'd1) : prod_q;
        fix_result  = signed_prod +
                      (((op_q == MD_MADD) || (op_q == MD_MADDU)) ? snap_q : '0);
`ifdef MDU_EARLY_OUT_EN
        run_end     = (cnt_q == 6'd1) || (mplier_next == '0);
`else
        run_end     = (cnt_q == 6'd1);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= MD_MULT;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            prod_q   <= '0;
            snap_q   <= '0;
            cnt_q    <= '0;
            sh_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
                        op_q     <= op_in;
                        mcand_q  <= a_abs;
                        mplier_q <= b_abs;
                        neg_q    <= signed_op & (src_a[31] ^ src_b[31]);
                        prod_q   <= '0;
                        snap_q   <= {hi_q, lo_q};
                        cnt_q    <= 6'(N);
                        sh_q     <= '0;
                    end
                end
                RUN: begin
                    prod_q   <= prod_step;
                    mplier_q <= mplier_next;
                    cnt_q    <= cnt_q - 6'd1;
                    sh_q     <= sh_q + 6'(BPC);
                    if (run_end) begin
                        state_q <= FIX;
                        done_q  <= 1'b1;
                    end
                end
                FIX: begin
                    {hi_q, lo_q} <= fix_result;
                    state_q      <= IDLE;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign stall   = busy_q & (rd_req | start);
    assign rd_data = rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer (BPC = 1).
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        rd_req = 1'b0;
    logic        rd_sel = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic        stall;
    logic [31:0] rd_data;
    logic        done;

    int unsigned errors = 0;
    int unsigned checks = 0;

    mdu_sequencer #(.BPC(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .rd_req  (rd_req),
        .rd_sel  (rd_sel),
        .flush   (flush),
        .busy    (busy),
        .stall   (stall),
        .rd_data (rd_data),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // expected done cycle given the number of significant multiplier bits
    function automatic int unsigned dcyc(input int unsigned steps);
`ifdef MDU_EARLY_OUT_EN
        return steps + 1;
`else
        return 33 + 0 * steps;
`endif
    endfunction

    task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        rd_sel = 1'b0;
        #1 chk({tag, "_lo"}, 64'(rd_data), 64'(exp_lo));
        rd_sel = 1'b1;
        #1 chk({tag, "_hi"}, 64'(rd_data), 64'(exp_hi));
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int unsigned exp_done,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int unsigned cyc;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_cycle"}, 64'(cyc), 64'(exp_done));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        read_hilo(tag, exp_hi, exp_lo);
    endtask

    initial begin
        int unsigned stall_cnt;
        int unsigned done_seen;

        repeat (2) @(negedge clk);
        rd_req = 1'b1;
        start  = 1'b1;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        read_hilo("rst", 32'h0, 32'h0);
        reset  = 1'b0;
        start  = 1'b0;
        rd_req = 1'b0;

        run_op("mult_neg3x7", 2'b00, 32'hFFFFFFFD, 32'd7, dcyc(3), 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_minint", 2'b00, 32'h80000000, 32'h80000000, 33, 32'h40000000, 32'h0);
        run_op("multu_5x1", 2'b01, 32'd5, 32'd1, dcyc(1), 32'h0, 32'h5);
        run_op("madd_2x3", 2'b10, 32'd2, 32'd3, dcyc(2), 32'h0, 32'h0000000B);
        run_op("multu_1x1", 2'b01, 32'd1, 32'd1, dcyc(1), 32'h0, 32'h1);
        run_op("maddu_carry", 2'b11, 32'hFFFFFFFF, 32'd1, dcyc(1), 32'h1, 32'h0);

        // MFHI during a MULT, plus a rejected start while busy
        @(negedge clk);
        start = 1'b1; op = 2'b00; src_a = 32'd6; src_b = 32'h80000000;
        stall_cnt = 0;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start  = 1'b0;
                rd_req = 1'b1;
                rd_sel = 1'b1;
            end
            if (c == 5) begin
                start = 1'b1; op = 2'b01; src_a = 32'd1; src_b = 32'd1;
            end
            if (c == 6) start = 1'b0;
            #1;
            if (stall === 1'b1) stall_cnt++;
            if (c == 33) chk("rd_stall_done", 64'(done), 64'd1);
        end
        chk("rd_stall_cycles", 64'(stall_cnt), 64'd33);
        @(negedge clk);
        #1;
        chk("rd_stall_c34", 64'(stall), 64'd0);
        chk("rd_hi_c34", 64'(rd_data), 64'hFFFFFFFD);
        rd_req = 1'b0;
        @(negedge clk);
        chk("busy_start_rejected", 64'(busy), 64'd0);
        read_hilo("busy_start_rejected", 32'hFFFFFFFD, 32'h0);

        // HI:LO = 0x12:0x34 then flush a MULT at c10
        run_op("pre_multu", 2'b01, 32'h24, 32'h80000000, 33, 32'h12, 32'h0);
        run_op("pre_maddu", 2'b11, 32'h34, 32'd1, dcyc(1), 32'h12, 32'h34);
        @(negedge clk);
        start = 1'b1; op = 2'b00; src_a = 32'd3; src_b = 32'h80000000;
        done_seen = 0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 11) flush = 1'b0;
            #1;
            if (done === 1'b1) done_seen++;
            if (c == 10) flush = 1'b1;
        end
        chk("flush_idle_c11", 64'(busy), 64'd0);
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        chk("flush_no_done", 64'(done_seen), 64'd0);
        read_hilo("flush_keep", 32'h12, 32'h34);

        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b01; src_a = 32'd9; src_b = 32'd9;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1 chk("start_flush_noissue", 64'(busy), 64'd0);
        done_seen = 0;
        repeat (35) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        chk("start_flush_no_done", 64'(done_seen), 64'd0);
        read_hilo("start_flush_keep", 32'h12, 32'h34);

        // reset mid-operation aborts and clears HI/LO
        @(negedge clk);
        start = 1'b1; op = 2'b01; src_a = 32'd7; src_b = 32'h80000000;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1 chk("midreset_busy", 64'(busy), 64'd0);
        read_hilo("midreset", 32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
